// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, error bit indices and sequencer state encoding
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam int ERR_OVF = 0;
    localparam int ERR_DZ  = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MOD;
    endfunction

endpackage

// File: rtl/alu_lat_timer.sv
// rtl/alu_lat_timer.sv - loadable down-counter that flags when the wait has elapsed
module alu_lat_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - registered command/response front-end for the 16-bit ALU
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_chain,
    input  logic        acc_clr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_error,
    output logic [31:0] acc,
    output logic        busy
);

    state_t state;
    logic   accept;
    logic   done;
    logic   capture;
    logic   acc_load;

    // Illegal opcodes get a zero count, so they share the one-cycle response slot of add/sub.
    function automatic logic [CNT_W-1:0] wait_count(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB: return CNT_W'(ADD_LAT - 1);
            OP_MUL:         return CNT_W'(MUL_LAT - 1);
            OP_DIV, OP_MOD: return CNT_W'(DIV_LAT - 1);
            default:        return '0;
        endcase
    endfunction

    assign accept   = (state == IDLE) && cmd_valid;
    assign capture  = (state == WAIT) && done;
    assign acc_load = capture && op_legal(alu_op) && !alu_error[ERR_DZ];

    alu_lat_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .value (wait_count(cmd_op)),
        .dec   (state == WAIT),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_NOP;
            rsp_result <= '0;
            rsp_error  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a  <= cmd_chain ? acc[15:0] : cmd_a;
                        alu_b  <= cmd_b;
                        alu_op <= cmd_op;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        if (op_legal(alu_op)) begin
                            rsp_result <= alu_result;
                            rsp_error  <= alu_error;
                        end else begin
                            rsp_result <= '0;
                            rsp_error  <= 2'b11;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A result landing on the same edge as a clear takes precedence over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (acc_load) begin
            acc <= alu_result;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_chain;
    logic        acc_clr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [1:0]  alu_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_error;
    logic [31:0] acc;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] acc_m;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_chain  (cmd_chain),
        .acc_clr    (acc_clr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .acc        (acc),
        .busy       (busy)
    );

    function automatic logic [33:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
        logic [31:0] r;
        logic [1:0]  e;
        r = '0;
        e = '0;
        case (op)
            4'd0: r = 32'(a) + 32'(b);
            4'd1: begin r = 32'(a) - 32'(b); e[0] = (a < b); end
            4'd2: r = 32'(a) * 32'(b);
            4'd3: if (b == 16'd0) e = 2'b10; else r = 32'(a / b);
            4'd4: if (b == 16'd0) e = 2'b10; else r = 32'(a % b);
            default: r = 32'hDEAD_BEEF;
        endcase
        return {e, r};
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: return 1;
            4'd2:       return 4;
            4'd3, 4'd4: return 8;
            default:    return 1;
        endcase
    endfunction

    // Behavioural ALU sitting on the registered operand bus.
    always_comb {alu_error, alu_result} = alu_ref(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic chain, input logic clr_acc, input logic clr_cap,
                          input int hold);
        logic [15:0] ea;
        logic [33:0] exp_v;
        logic [31:0] eres;
        logic [1:0]  eerr;
        logic        legal;
        logic        bad;
        int          lat;
        int          cycles;

        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        ea    = chain ? acc_m[15:0] : a;
        legal = (op <= 4'd4);
        lat   = lat_of(op);
        exp_v = alu_ref(ea, b, op);
        eres  = legal ? exp_v[31:0] : 32'd0;
        eerr  = legal ? exp_v[33:32] : 2'b11;

        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; acc_clr = clr_acc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_chain = 1'b0;
        if (clr_acc) acc_m = '0;
        cycles  = 0;
        acc_clr = (lat == 1) ? clr_cap : 1'b0;
        check("alu_a", 32'(alu_a), 32'(ea));
        check("alu_b", 32'(alu_b), 32'(b));
        check("alu_op", 32'(alu_op), 32'(op));
        check("busy", 32'(busy), 32'd1);

        bad = 1'b0;
        while (!rsp_valid && cycles < 40) begin
            if (cmd_ready || alu_a !== ea) bad = 1'b1;
            @(negedge clk);
            cycles++;
            acc_clr = (cycles == lat - 1) ? clr_cap : 1'b0;
        end
        acc_clr = 1'b0;
        check("latency", 32'(cycles), 32'(lat));
        check("wait_stable", 32'(bad), 32'd0);

        if (legal && !eerr[1]) acc_m = eres;
        else if (clr_cap) acc_m = '0;
        check("rsp_result", rsp_result, eres);
        check("rsp_error", 32'(rsp_error), 32'(eerr));
        check("acc", acc, acc_m);

        // Offer a competing command while the response is stalled; it must not be taken.
        cmd_valid = (hold > 0); cmd_op = op ^ 4'h1; cmd_a = ~ea; cmd_chain = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_result !== eres || cmd_ready || alu_a !== ea) bad = 1'b1;
        end
        if (hold > 0) check("backpressure", 32'(bad), 32'd0);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("ready_back", 32'(cmd_ready), 32'd1);
        check("no_early_accept", 32'(alu_a), 32'(ea));
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'hF);
        check({tag, "_rsp_result"}, rsp_result, 32'd0);
        check({tag, "_acc"}, acc, 32'd0);
    endtask

    initial begin
        logic        seen;
        logic [3:0]  r_op;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_chain = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b0;
        acc_m = '0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_cmd(4'd0, 16'd15, 16'd126, 1'b0, 1'b0, 1'b1, 0);
        do_cmd(4'd2, 16'd15, 16'd126, 1'b0, 1'b0, 1'b0, 0);
        do_cmd(4'd3, 16'd0, 16'd15, 1'b1, 1'b0, 1'b0, 0);
        do_cmd(4'd4, 16'd99, 16'd0, 1'b0, 1'b0, 1'b0, 0);
        do_cmd(4'd7, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 5);
        do_cmd(4'd1, 16'd5, 16'd9, 1'b1, 1'b1, 1'b0, 2);

        // Reset while a multiply is in flight: no response may follow.
        cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 16'd7; cmd_b = 16'd9; cmd_chain = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b1;
        acc_m = '0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);

        for (int n = 0; n < 40; n++) begin
            r_op = ($urandom_range(0, 5) == 5) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            do_cmd(r_op, 16'($urandom), ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
